// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with occupancy count, programmable almost-full/
// almost-empty thresholds, registered or first-word-fall-through read port and
// sticky overflow/underflow flags.
module sync_fifo_ctl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = DEPTH - 1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          pop_data_o,
    output logic                       pop_valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    input  logic                       clr_err_i
);

    localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              pop_acc;
    logic              push_acc;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Status flags all derive from the registered occupancy.
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == FULL_CNT);
    assign almost_full_o  = (count_q >= AF_CNT);
    assign almost_empty_o = (count_q <= AE_CNT);
    assign count_o        = count_q;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign pop_acc  = pop_i & ~empty_o;
    assign push_acc = push_i & (~full_o | pop_acc);

    // Storage array; contents survive reset, writes are blocked while in reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_acc) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_acc && !pop_acc) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_i && !push_acc) begin
                overflow_o <= 1'b1;
            end else if (clr_err_i) begin
                overflow_o <= 1'b0;
            end
            if (pop_i && !pop_acc) begin
                underflow_o <= 1'b1;
            end else if (clr_err_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; pop_i acknowledges it.
        assign pop_data_o  = mem[rd_ptr];
        assign pop_valid_o = ~empty_o;
    end else begin : g_reg
        // Registered read: data and a one-cycle valid pulse follow an accepted pop.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pop_data_o  <= '0;
                pop_valid_o <= 1'b0;
            end else begin
                pop_valid_o <= pop_acc;
                if (pop_acc) begin
                    pop_data_o <= mem[rd_ptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Scoreboard bench for sync_fifo_ctl: a registered-read DEPTH=4 instance and a
// first-word-fall-through DEPTH=5 instance, each against a queue-based model.
module tb_sync_fifo_ctl;

    localparam int D0 = 4;
    localparam int D1 = 5;

    typedef struct {
        int         due;
        bit         is_rst;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: DEPTH=4, registered read
    logic       rst0 = 1'b1, push0 = 1'b0, pop0 = 1'b0, clr0 = 1'b0;
    logic [7:0] pdata0 = 8'h00;
    logic [7:0] pop_data0;
    logic       pop_valid0, full0, empty0, afull0, aempty0, ovf0_o, unf0_o;
    logic [2:0] count0;

    // Instance 1: DEPTH=5, first-word-fall-through
    logic       rst1 = 1'b1, push1 = 1'b0, pop1 = 1'b0, clr1 = 1'b0;
    logic [7:0] pdata1 = 8'h00;
    logic [7:0] pop_data1;
    logic       pop_valid1, full1, empty1, afull1, aempty1, ovf1_o, unf1_o;
    logic [2:0] count1;

    sync_fifo_ctl #(.DATA_W(8), .DEPTH(D0), .FWFT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .push_i(push0), .push_data_i(pdata0),
        .pop_i(pop0), .pop_data_o(pop_data0), .pop_valid_o(pop_valid0),
        .full_o(full0), .empty_o(empty0), .almost_full_o(afull0),
        .almost_empty_o(aempty0), .count_o(count0), .overflow_o(ovf0_o),
        .underflow_o(unf0_o), .clr_err_i(clr0)
    );

    sync_fifo_ctl #(.DATA_W(8), .DEPTH(D1), .FWFT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .push_i(push1), .push_data_i(pdata1),
        .pop_i(pop1), .pop_data_o(pop_data1), .pop_valid_o(pop_valid1),
        .full_o(full1), .empty_o(empty1), .almost_full_o(afull1),
        .almost_empty_o(aempty1), .count_o(count1), .overflow_o(ovf1_o),
        .underflow_o(unf1_o), .clr_err_i(clr1)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [7:0] m0[$];
    logic [7:0] m1[$];
    exp_t       exp0[$];
    logic [7:0] exp1[$];
    bit         ovf0 = 1'b0, unf0 = 1'b0, ovf1 = 1'b0, unf1 = 1'b0;
    logic [7:0] last0 = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor for the registered-read port: every edge either delivers the
    // scheduled word with a valid pulse, reflects a reset, or holds quietly.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (exp0.size() > 0 && exp0[0].due < cyc) begin
                e = exp0.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL pop0_late at cycle %0d: expected word 0x%0h due cycle %0d not seen", cyc, e.data, e.due);
            end
            if (exp0.size() > 0 && exp0[0].due == cyc) begin
                e = exp0.pop_front();
                if (e.is_rst) begin
                    chk("pop_valid0_rst", int'(pop_valid0), 0);
                    chk("pop_data0_rst", int'(pop_data0), 0);
                    last0 = 8'h00;
                end else begin
                    chk("pop_valid0", int'(pop_valid0), 1);
                    chk("pop_data0", int'(pop_data0), int'(e.data));
                    last0 = e.data;
                end
            end else begin
                chk("pop_valid0_idle", int'(pop_valid0), 0);
                chk("pop_data0_hold", int'(pop_data0), int'(last0));
            end
        end
    end

    // Monitor for the FWFT port: each acknowledged head word must be the next
    // word in write order.
    always @(negedge clk) begin
        if (mon_en && !rst1 && pop1 && pop_valid1) begin
            if (exp1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL fwft_head at cycle %0d: got 0x%0h, expected no word present", cyc, pop_data1);
            end else begin
                chk("fwft_head", int'(pop_data1), int'(exp1.pop_front()));
            end
        end
    end

    task automatic step0(input bit ps, input logic [7:0] d, input bit pp, input bit clr, input bit rs);
        exp_t e;
        bit   pa;
        bit   wa;
        push0 = ps; pdata0 = d; pop0 = pp; clr0 = clr; rst0 = rs;
        if (rs) begin
            m0.delete();
            ovf0 = 1'b0;
            unf0 = 1'b0;
            e.due = cyc + 1; e.is_rst = 1'b1; e.data = 8'h00;
            exp0.push_back(e);
        end else begin
            pa = pp && (m0.size() > 0);
            wa = ps && ((m0.size() < D0) || pa);
            if (pa) begin
                e.due = cyc + 1; e.is_rst = 1'b0; e.data = m0.pop_front();
                exp0.push_back(e);
            end
            if (wa) m0.push_back(d);
            ovf0 = (ps && !wa) ? 1'b1 : (clr ? 1'b0 : ovf0);
            unf0 = (pp && !pa) ? 1'b1 : (clr ? 1'b0 : unf0);
        end
        @(posedge clk);
        #1;
        chk("count0", int'(count0), m0.size());
        chk("full0", int'(full0), int'(m0.size() == D0));
        chk("empty0", int'(empty0), int'(m0.size() == 0));
        chk("afull0", int'(afull0), int'(m0.size() >= D0 - 1));
        chk("aempty0", int'(aempty0), int'(m0.size() <= 1));
        chk("overflow0", int'(ovf0_o), int'(ovf0));
        chk("underflow0", int'(unf0_o), int'(unf0));
        push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; rst0 = 1'b0;
    endtask

    task automatic step1(input bit ps, input logic [7:0] d, input bit pp, input bit clr, input bit rs,
                         output bit wa);
        bit pa;
        push1 = ps; pdata1 = d; pop1 = pp; clr1 = clr; rst1 = rs;
        wa = 1'b0;
        if (rs) begin
            m1.delete();
            exp1.delete();
            ovf1 = 1'b0;
            unf1 = 1'b0;
        end else begin
            pa = pp && (m1.size() > 0);
            wa = ps && ((m1.size() < D1) || pa);
            if (pa) void'(m1.pop_front());
            if (wa) begin
                m1.push_back(d);
                exp1.push_back(d);
            end
            ovf1 = (ps && !wa) ? 1'b1 : (clr ? 1'b0 : ovf1);
            unf1 = (pp && !pa) ? 1'b1 : (clr ? 1'b0 : unf1);
        end
        @(posedge clk);
        #1;
        chk("count1", int'(count1), m1.size());
        chk("full1", int'(full1), int'(m1.size() == D1));
        chk("empty1", int'(empty1), int'(m1.size() == 0));
        chk("afull1", int'(afull1), int'(m1.size() >= D1 - 1));
        chk("aempty1", int'(aempty1), int'(m1.size() <= 1));
        chk("pop_valid1", int'(pop_valid1), int'(m1.size() > 0));
        if (m1.size() > 0) chk("head1", int'(pop_data1), int'(m1[0]));
        chk("overflow1", int'(ovf1_o), int'(ovf1));
        chk("underflow1", int'(unf1_o), int'(unf1));
        push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0; rst1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        bit acc;
        int next_w;
        int n;

        // Reset both instances
        step0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step1(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Fill and drain in order
        step0(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Overflow while full, then push+pop at full
        for (int i = 0; i < 4; i++) step0(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Underflow on empty, set beats clear, then clear alone
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step0(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Push into empty with simultaneous pop: pop rejected, push accepted
        step0(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        step0(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Random traffic on the registered-read instance
        for (int i = 0; i < 150; i++) begin
            step0(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
        end

        // Reset mid-traffic with push and pop asserted
        step0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step0(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // FWFT stream of 0..11 with random gaps across pointer wrap
        next_w = 0;
        n = 0;
        while (!(next_w == 12 && m1.size() == 0) && n < 400) begin
            step1((next_w < 12) && ($urandom_range(0, 2) != 0), 8'(next_w),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0, acc);
            if (acc) next_w++;
            n++;
        end
        if (n >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL fwft_stream: got %0d words written, expected 12 written and drained", next_w);
        end
        chk("fwft_drained", exp1.size(), 0);

        // Random traffic on the FWFT instance
        for (int i = 0; i < 150; i++) begin
            step1(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, acc);
        end
        step1(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, acc);
        step1(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
